// File: rtl/pspin_cmd_resp_router_if.sv
// Bundle of every handshake, bus and status signal around the PsPIN command
// completion router. Signal names are the router's own port names.
//   issue_valid_i / issue_cmd_id_i       issue pulse and the cmd_id of the issued command
//   resp_valid_i / resp_ready_o /
//   resp_cmd_id_i                        completions arriving from the command interfaces
//   cl_resp_valid_o / cl_resp_ready_i /
//   cl_resp_cmd_id_o                     completions delivered to each cluster
//   core_inflight_o                      in-flight command count per HPU
//   spurious_resp_o / issue_overflow_o   protocol-violation pulses
// The master modport belongs to the environment. The slave modport belongs to the router.
interface pspin_cmd_resp_router_if #(
  parameter int NUM_CLUSTERS       = 4,
  parameter int NUM_CORES          = 8,
  parameter int NUM_HPU_CMDS       = 4,
  parameter int NUM_CMD_INTERFACES = 4
);
  localparam int ID_W  = $clog2(NUM_CLUSTERS) + $clog2(NUM_CORES) + $clog2(NUM_HPU_CMDS);
  localparam int CNT_W = $clog2(NUM_HPU_CMDS) + 1;

  logic                                      issue_valid_i;
  logic [ID_W-1:0]                           issue_cmd_id_i;
  logic [NUM_CMD_INTERFACES-1:0]             resp_valid_i;
  logic [NUM_CMD_INTERFACES-1:0]             resp_ready_o;
  logic [NUM_CMD_INTERFACES*ID_W-1:0]        resp_cmd_id_i;
  logic [NUM_CLUSTERS-1:0]                   cl_resp_valid_o;
  logic [NUM_CLUSTERS-1:0]                   cl_resp_ready_i;
  logic [NUM_CLUSTERS*ID_W-1:0]              cl_resp_cmd_id_o;
  logic [NUM_CLUSTERS*NUM_CORES*CNT_W-1:0]   core_inflight_o;
  logic                                      spurious_resp_o;
  logic                                      issue_overflow_o;

  modport master (
    output issue_valid_i, issue_cmd_id_i, resp_valid_i, resp_cmd_id_i, cl_resp_ready_i,
    input  resp_ready_o, cl_resp_valid_o, cl_resp_cmd_id_o, core_inflight_o,
           spurious_resp_o, issue_overflow_o
  );

  modport slave (
    input  issue_valid_i, issue_cmd_id_i, resp_valid_i, resp_cmd_id_i, cl_resp_ready_i,
    output resp_ready_o, cl_resp_valid_o, cl_resp_cmd_id_o, core_inflight_o,
           spurious_resp_o, issue_overflow_o
  );
endinterface

// File: rtl/pspin_cmd_resp_router.sv
// PsPIN command completion return path.
// Completions from the command interfaces are routed to the issuing cluster
// through a single-entry output register per cluster. Each cluster has its own
// round-robin arbiter. The router also keeps a saturating in-flight counter for
// every HPU and pulses a flag when a completion arrives for an idle HPU or when
// an issue overflows the per-HPU limit.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous, active-high reset
//   bus    pspin_cmd_resp_router_if.slave: issue, completion input/output
//          handshakes, per-HPU counts and violation pulses
module pspin_cmd_resp_router #(
  parameter int NUM_CLUSTERS       = 4,
  parameter int NUM_CORES          = 8,
  parameter int NUM_HPU_CMDS       = 4,
  parameter int NUM_CMD_INTERFACES = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  pspin_cmd_resp_router_if.slave   bus
);
  localparam int CORE_W   = $clog2(NUM_CORES);
  localparam int LCMD_W   = $clog2(NUM_HPU_CMDS);
  localparam int ID_W     = $clog2(NUM_CLUSTERS) + CORE_W + LCMD_W;
  localparam int CNT_W    = LCMD_W + 1;
  localparam int NUM_HPUS = NUM_CLUSTERS * NUM_CORES;
  localparam int NIF      = NUM_CMD_INTERFACES;
  localparam int RR_W     = (NIF > 1) ? $clog2(NIF) : 1;

  logic [ID_W-1:0]         resp_id [NIF];
  int                      resp_cl [NIF];
  logic [NUM_CLUSTERS-1:0] cl_valid_q;
  logic [ID_W-1:0]         cl_id_q [NUM_CLUSTERS];
  logic [RR_W-1:0]         rr_q    [NUM_CLUSTERS];
  logic [RR_W-1:0]         rr_d    [NUM_CLUSTERS];
  logic [NUM_CLUSTERS-1:0] free;
  logic [NUM_CLUSTERS-1:0] gnt_vld;
  logic [RR_W-1:0]         gnt_idx [NUM_CLUSTERS];
  logic [NIF-1:0]          grant;
  logic [CNT_W-1:0]        cnt_q   [NUM_HPUS];
  logic [CNT_W-1:0]        cnt_d   [NUM_HPUS];
  logic [NUM_HPUS-1:0]     inc;
  logic [NUM_HPUS-1:0]     dec;
  logic                    spur_d, spur_q;
  logic                    ovf_d, ovf_q;

  function automatic int wrap_idx(logic [RR_W-1:0] base, int off);
    int s;
    s = int'(base) + off;
    return (s >= NIF) ? s - NIF : s;
  endfunction

  // Arbitration. A cluster can accept a new completion when its output register
  // is empty or is being drained in this cycle.
  always_comb begin
    grant   = '0;
    gnt_vld = '0;
    free    = '0;
    for (int i = 0; i < NIF; i++) begin
      resp_id[i] = bus.resp_cmd_id_i[i*ID_W +: ID_W];
      resp_cl[i] = int'(resp_id[i] >> (CORE_W + LCMD_W));
    end
    for (int c = 0; c < NUM_CLUSTERS; c++) begin
      gnt_idx[c] = '0;
      rr_d[c]    = rr_q[c];
      free[c]    = !cl_valid_q[c] || bus.cl_resp_ready_i[c];
      for (int off = 0; off < NIF; off++) begin
        if (free[c] && !gnt_vld[c] && bus.resp_valid_i[wrap_idx(rr_q[c], off)] &&
            resp_cl[wrap_idx(rr_q[c], off)] == c) begin
          gnt_vld[c]                     = 1'b1;
          gnt_idx[c]                     = RR_W'(wrap_idx(rr_q[c], off));
          grant[wrap_idx(rr_q[c], off)]  = 1'b1;
          rr_d[c]                        = RR_W'(wrap_idx(rr_q[c], off + 1));
        end
      end
    end
  end

  // Per-HPU counters. With a power-of-two core count, cmd_id >> LCMD_W equals
  // cluster*NUM_CORES + core. Each cluster has at most one grant, so each HPU
  // gets at most one decrement per cycle.
  always_comb begin
    inc    = '0;
    dec    = '0;
    spur_d = 1'b0;
    ovf_d  = 1'b0;
    if (bus.issue_valid_i) inc[int'(bus.issue_cmd_id_i >> LCMD_W)] = 1'b1;
    for (int c = 0; c < NUM_CLUSTERS; c++) begin
      if (gnt_vld[c]) dec[int'(resp_id[gnt_idx[c]] >> LCMD_W)] = 1'b1;
    end
    for (int k = 0; k < NUM_HPUS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (inc[k] && !dec[k]) begin
        if (cnt_q[k] == CNT_W'(NUM_HPU_CMDS)) ovf_d = 1'b1;
        else                                  cnt_d[k] = cnt_q[k] + 1'b1;
      end else if (dec[k] && !inc[k]) begin
        if (cnt_q[k] == '0) spur_d = 1'b1;
        else                cnt_d[k] = cnt_q[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cl_valid_q <= '0;
      spur_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int c = 0; c < NUM_CLUSTERS; c++) begin
        cl_id_q[c] <= '0;
        rr_q[c]    <= '0;
      end
      for (int k = 0; k < NUM_HPUS; k++) cnt_q[k] <= '0;
    end else begin
      for (int c = 0; c < NUM_CLUSTERS; c++) begin
        if (free[c]) cl_valid_q[c] <= gnt_vld[c];
        if (gnt_vld[c]) cl_id_q[c] <= resp_id[gnt_idx[c]];
        rr_q[c] <= rr_d[c];
      end
      for (int k = 0; k < NUM_HPUS; k++) cnt_q[k] <= cnt_d[k];
      spur_q <= spur_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    bus.resp_ready_o     = grant;
    bus.cl_resp_valid_o  = cl_valid_q;
    bus.spurious_resp_o  = spur_q;
    bus.issue_overflow_o = ovf_q;
    bus.cl_resp_cmd_id_o = '0;
    bus.core_inflight_o  = '0;
    for (int c = 0; c < NUM_CLUSTERS; c++) bus.cl_resp_cmd_id_o[c*ID_W +: ID_W] = cl_id_q[c];
    for (int k = 0; k < NUM_HPUS; k++) bus.core_inflight_o[k*CNT_W +: CNT_W] = cnt_q[k];
  end
endmodule

// File: tb/tb_pspin_cmd_resp_router.sv
// Testbench for pspin_cmd_resp_router.
// Runs a table of directed cycles with hand-derived expectations, a mid-transfer
// asynchronous reset sequence, and a randomized phase. Every cycle is also
// checked against a behavioural reference model.
module tb_pspin_cmd_resp_router;
  localparam int NCL  = 4;
  localparam int NCO  = 8;
  localparam int NIF  = 4;
  localparam int NHPU = NCL * NCO;
  localparam int MAXC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pspin_cmd_resp_router_if bus ();
  pspin_cmd_resp_router dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(string name, logic [127:0] got, logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one output slot per cluster, a round-robin start per
  // cluster, and a saturating count per HPU.
  bit         m_v   [NCL];
  logic [6:0] m_id  [NCL];
  int         m_rr  [NCL];
  int         m_cnt [NHPU];
  bit         m_spur, m_ovf;

  function automatic void model_reset();
    for (int c = 0; c < NCL; c++) begin m_v[c] = 0; m_id[c] = '0; m_rr[c] = 0; end
    for (int k = 0; k < NHPU; k++) m_cnt[k] = 0;
    m_spur = 0; m_ovf = 0;
  endfunction

  function automatic int hpu_of(logic [6:0] id);
    return int'(id[6:5]) * NCO + int'(id[4:2]);
  endfunction

  function automatic logic [3:0] model_grants(logic [3:0] rv, logic [27:0] rids, logic [3:0] crdy);
    logic [3:0] g;
    g = '0;
    for (int c = 0; c < NCL; c++) begin
      if (!m_v[c] || crdy[c]) begin
        for (int off = 0; off < NIF; off++) begin
          int i;
          i = (m_rr[c] + off) % NIF;
          if (rv[i] && int'(rids[i*7+5 +: 2]) == c) begin g[i] = 1'b1; break; end
        end
      end
    end
    return g;
  endfunction

  task automatic model_step(bit iv, logic [6:0] iid, logic [3:0] rv, logic [27:0] rids, logic [3:0] crdy);
    logic [3:0] g;
    bit dec [NHPU];
    int inc_k;
    g = model_grants(rv, rids, crdy);
    for (int k = 0; k < NHPU; k++) dec[k] = 0;
    for (int c = 0; c < NCL; c++) begin
      if (!m_v[c] || crdy[c]) begin
        m_v[c] = 0;
        for (int i = 0; i < NIF; i++) begin
          if (g[i] && int'(rids[i*7+5 +: 2]) == c) begin
            m_v[c] = 1; m_id[c] = rids[i*7 +: 7]; m_rr[c] = (i + 1) % NIF;
          end
        end
      end
    end
    for (int i = 0; i < NIF; i++) if (g[i]) dec[hpu_of(rids[i*7 +: 7])] = 1;
    inc_k = iv ? hpu_of(iid) : -1;
    m_spur = 0; m_ovf = 0;
    for (int k = 0; k < NHPU; k++) begin
      if (k == inc_k && !dec[k]) begin
        if (m_cnt[k] == MAXC) m_ovf = 1; else m_cnt[k]++;
      end else if (dec[k] && k != inc_k) begin
        if (m_cnt[k] == 0) m_spur = 1; else m_cnt[k]--;
      end
    end
  endtask

  task automatic check_regs();
    logic [3:0]  ev;
    logic [27:0] eid;
    logic [95:0] ecnt;
    for (int c = 0; c < NCL; c++) begin ev[c] = m_v[c]; eid[c*7 +: 7] = m_id[c]; end
    for (int k = 0; k < NHPU; k++) ecnt[k*3 +: 3] = 3'(m_cnt[k]);
    check("cl_valid", bus.cl_resp_valid_o, ev);
    check("cl_cmd_id", bus.cl_resp_cmd_id_o, eid);
    check("inflight", bus.core_inflight_o, ecnt);
    check("spurious", bus.spurious_resp_o, m_spur);
    check("overflow", bus.issue_overflow_o, m_ovf);
  endtask

  logic [3:0] last_rdy;

  // Called at posedge+1: drive the inputs, check ready before the edge, then step
  // the model and check the registered outputs after the edge.
  task automatic apply(bit iv, logic [6:0] iid, logic [3:0] rv, logic [27:0] rids,
                       logic [3:0] crdy, output logic [3:0] gnt);
    bus.issue_valid_i   = iv;
    bus.issue_cmd_id_i  = iid;
    bus.resp_valid_i    = rv;
    bus.resp_cmd_id_i   = rids;
    bus.cl_resp_ready_i = crdy;
    #3;
    gnt      = model_grants(rv, rids, crdy);
    last_rdy = bus.resp_ready_o;
    check("resp_ready", last_rdy, gnt);
    @(posedge clk);
    model_step(iv, iid, rv, rids, crdy);
    #1;
    check_regs();
  endtask

  typedef struct {
    bit          iv;
    logic [6:0]  iid;
    logic [3:0]  rv;
    logic [27:0] rids;
    logic [3:0]  crdy;
    logic [3:0]  e_rdy;
    logic [3:0]  e_clv;
    bit          e_spur;
    bit          e_ovf;
    int          e_k;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit iv, logic [6:0] iid, logic [3:0] rv, logic [27:0] rids,
                              logic [3:0] crdy, logic [3:0] e_rdy, logic [3:0] e_clv,
                              bit e_spur, bit e_ovf, int e_k, int e_cnt);
    vec_t v;
    v.iv = iv; v.iid = iid; v.rv = rv; v.rids = rids; v.crdy = crdy;
    v.e_rdy = e_rdy; v.e_clv = e_clv; v.e_spur = e_spur; v.e_ovf = e_ovf;
    v.e_k = e_k; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  function automatic logic [27:0] ids4(logic [6:0] a3, logic [6:0] a2, logic [6:0] a1, logic [6:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [6:0] rnd_id();
    return {2'($urandom_range(3, 0)), 3'($urandom_range(1, 0)), 2'($urandom_range(3, 0))};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  g;
    logic [3:0]  pend;
    logic [6:0]  pid [NIF];
    bit          iv;

    bus.issue_valid_i = 0; bus.issue_cmd_id_i = '0; bus.resp_valid_i = '0;
    bus.resp_cmd_id_i = '0; bus.cl_resp_ready_i = '0;
    model_reset();

    // Single path: {cl1,core2,cmd3}=0x2B issued, completed by IF2 three cycles later
    add(1, 7'h2B, 4'h0, '0, 4'hF, 4'h0, 4'h0, 0, 0, 10, 1);
    add(0, 7'h00, 4'h0, '0, 4'hF, 4'h0, 4'h0, 0, 0, 10, 1);
    add(0, 7'h00, 4'h0, '0, 4'hF, 4'h0, 4'h0, 0, 0, 10, 1);
    add(0, 7'h00, 4'b0100, ids4(0, 7'h2B, 0, 0), 4'hF, 4'b0100, 4'b0010, 0, 0, 10, 0);
    add(0, 7'h00, 4'h0, '0, 4'hF, 4'h0, 4'h0, 0, 0, 10, 0);
    // Round-robin on cluster 0 (HPU 1 idle -> spurious each grant)
    add(0, 7'h00, 4'b1111, ids4(7'h07, 7'h06, 7'h05, 7'h04), 4'hF, 4'b0001, 4'b0001, 1, 0, 1, 0);
    add(0, 7'h00, 4'b1110, ids4(7'h07, 7'h06, 7'h05, 7'h04), 4'hF, 4'b0010, 4'b0001, 1, 0, 1, 0);
    add(0, 7'h00, 4'b1100, ids4(7'h07, 7'h06, 7'h05, 7'h04), 4'hF, 4'b0100, 4'b0001, 1, 0, 1, 0);
    add(0, 7'h00, 4'b1000, ids4(7'h07, 7'h06, 7'h05, 7'h04), 4'hF, 4'b1000, 4'b0001, 1, 0, 1, 0);
    add(0, 7'h00, 4'h0, '0, 4'hF, 4'h0, 4'h0, 0, 0, 1, 0);
    // Backpressure on cluster 2 for five cycles, IF1 and IF3 competing
    add(0, 7'h00, 4'b1010, ids4(7'h43, 0, 7'h41, 0), 4'b1011, 4'b0010, 4'b0100, 1, 0, 16, 0);
    for (int n = 0; n < 4; n++)
      add(0, 7'h00, 4'b1000, ids4(7'h43, 0, 0, 0), 4'b1011, 4'h0, 4'b0100, 0, 0, 16, 0);
    add(0, 7'h00, 4'b1000, ids4(7'h43, 0, 0, 0), 4'hF, 4'b1000, 4'b0100, 1, 0, 16, 0);
    add(0, 7'h00, 4'h0, '0, 4'hF, 4'h0, 4'h0, 0, 0, 16, 0);
    // Parallel: one interface per cluster
    add(0, 7'h00, 4'hF, ids4(7'h60, 7'h40, 7'h20, 7'h00), 4'hF, 4'hF, 4'hF, 1, 0, 0, 0);
    add(0, 7'h00, 4'h0, '0, 4'hF, 4'h0, 4'h0, 0, 0, 0, 0);
    // Five issues to HPU 0: saturate at 4, overflow pulse once
    for (int n = 0; n < 4; n++)
      add(1, 7'h00, 4'h0, '0, 4'hF, 4'h0, 4'h0, 0, 0, 0, n + 1);
    add(1, 7'h00, 4'h0, '0, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4);
    add(0, 7'h00, 4'h0, '0, 4'hF, 4'h0, 4'h0, 0, 0, 0, 4);
    // Same-cycle issue and completion for HPU 0
    add(1, 7'h00, 4'b0001, ids4(0, 0, 0, 7'h00), 4'hF, 4'b0001, 4'b0001, 0, 0, 0, 4);
    add(0, 7'h00, 4'h0, '0, 4'hF, 4'h0, 4'h0, 0, 0, 0, 4);
    // Completion for idle HPU 5 is flagged and still delivered
    add(0, 7'h00, 4'b0010, ids4(0, 0, 7'h14, 0), 4'hF, 4'b0010, 4'b0001, 1, 0, 5, 0);
    add(0, 7'h00, 4'h0, '0, 4'hF, 4'h0, 4'h0, 0, 0, 0, 4);

    repeat (2) @(posedge clk);
    #1;
    check("rst_cl_valid", bus.cl_resp_valid_o, 4'h0);
    check("rst_cl_cmd_id", bus.cl_resp_cmd_id_o, 28'h0);
    check("rst_inflight", bus.core_inflight_o, 96'h0);
    check("rst_pulses", {bus.spurious_resp_o, bus.issue_overflow_o}, 2'b00);
    rst = 0;

    for (int n = 0; n < vecs.size(); n++) begin
      apply(vecs[n].iv, vecs[n].iid, vecs[n].rv, vecs[n].rids, vecs[n].crdy, g);
      check($sformatf("vec%0d_ready", n), last_rdy, vecs[n].e_rdy);
      check($sformatf("vec%0d_cl_valid", n), bus.cl_resp_valid_o, vecs[n].e_clv);
      check($sformatf("vec%0d_spurious", n), bus.spurious_resp_o, vecs[n].e_spur);
      check($sformatf("vec%0d_overflow", n), bus.issue_overflow_o, vecs[n].e_ovf);
      check($sformatf("vec%0d_cnt%0d", n, vecs[n].e_k), bus.core_inflight_o[vecs[n].e_k*3 +: 3],
            vecs[n].e_cnt);
    end

    // Mid-transfer asynchronous reset while cluster 3 holds a completion
    apply(0, 7'h00, 4'b0100, ids4(0, 7'h60, 0, 0), 4'b0111, g);
    check("pre_rst_cl3_valid", bus.cl_resp_valid_o[3], 1'b1);
    check("pre_rst_cnt0", bus.core_inflight_o[2:0], 3'd4);
    bus.resp_valid_i = '0;
    #2 rst = 1;
    #1;
    check("async_rst_cl_valid", bus.cl_resp_valid_o, 4'h0);
    check("async_rst_cl_cmd_id", bus.cl_resp_cmd_id_o, 28'h0);
    check("async_rst_inflight", bus.core_inflight_o, 96'h0);
    check("async_rst_pulses", {bus.spurious_resp_o, bus.issue_overflow_o}, 2'b00);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    apply(0, 7'h00, 4'hF, ids4(7'h23, 7'h22, 7'h21, 7'h20), 4'hF, g);
    check("post_rst_rr_if0", last_rdy, 4'b0001);
    apply(0, 7'h00, 4'h0, '0, 4'hF, g);

    // Randomized traffic with source-side hold while not granted
    pend = '0;
    for (int i = 0; i < NIF; i++) pid[i] = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < NIF; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin pend[i] = 1'b1; pid[i] = rnd_id(); end
      end
      iv = ($urandom_range(99, 0) < 40);
      apply(iv, rnd_id(), pend, ids4(pid[3], pid[2], pid[1], pid[0]),
            {($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0),
             ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0)}, g);
      pend = pend & ~g;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
